// File: rtl/heartbeat_sequencer.sv
// heartbeat_sequencer: plays a lub-dub pattern by driving the clk_divider period code and enable.
// Define HB_COUNT_EN to add the saturating 16-bit beat_count output.
module heartbeat_sequencer #(
  parameter int unsigned TICK_DIV   = 12000,
  parameter int unsigned LUB_MS     = 100,
  parameter int unsigned GAP_MS     = 80,
  parameter int unsigned DUB_MS     = 100,
  parameter logic [3:0]  PERIOD_LUB = 4'd1,
  parameter logic [3:0]  PERIOD_DUB = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  bpm_sel,
  output logic [3:0]  period,
  output logic        div_en,
  output logic        busy,
  output logic        beat_pulse
`ifdef HB_COUNT_EN
  ,
  output logic [15:0] beat_count
`endif
);

  localparam int unsigned   TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int unsigned   BEAT_MS   = LUB_MS + GAP_MS + DUB_MS;

  typedef enum logic [2:0] {IDLE, LUB, GAP, DUB, REST} state_t;

  state_t        state_q;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic [15:0]   durCnt_q;
  logic          stopPend_q;
  logic [1:0]    bpmLat_q;
  logic [3:0]    period_q;
  logic          divEn_q, busy_q, beatPulse_q;
  logic          tick, expire;
`ifdef HB_COUNT_EN
  logic [15:0]   beatCnt_q;
`endif

  // REST fills whatever the selected cycle length leaves after the two tones and the gap.
  function automatic logic [15:0] restLoad(input logic [1:0] code);
    int unsigned cycleMs;
    case (code)
      2'd0:    cycleMs = 1000;
      2'd1:    cycleMs = 800;
      2'd2:    cycleMs = 600;
      default: cycleMs = 500;
    endcase
    return 16'(cycleMs - BEAT_MS - 1);
  endfunction

  always_comb begin
    tick      = (state_q != IDLE) && (tickCnt_q == TICK_LAST);
    expire    = tick && (durCnt_q == '0);
    tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tickCnt_q   <= '0;
      durCnt_q    <= '0;
      stopPend_q  <= 1'b0;
      bpmLat_q    <= '0;
      period_q    <= '0;
      divEn_q     <= 1'b0;
      busy_q      <= 1'b0;
      beatPulse_q <= 1'b0;
`ifdef HB_COUNT_EN
      beatCnt_q   <= '0;
`endif
    end else begin
      beatPulse_q <= 1'b0;
      if (state_q != IDLE) tickCnt_q <= tickCnt_d;
      if (tick) durCnt_q <= durCnt_q - 16'd1;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q     <= LUB;
            tickCnt_q   <= '0;
            durCnt_q    <= 16'(LUB_MS - 1);
            bpmLat_q    <= bpm_sel;
            period_q    <= PERIOD_LUB;
            divEn_q     <= 1'b1;
            busy_q      <= 1'b1;
            beatPulse_q <= 1'b1;
`ifdef HB_COUNT_EN
            beatCnt_q   <= 16'd1;
`endif
          end
        end
        LUB: begin
          if (stop) stopPend_q <= 1'b1;
          if (expire) begin
            state_q  <= GAP;
            durCnt_q <= 16'(GAP_MS - 1);
            period_q <= '0;
            divEn_q  <= 1'b0;
          end
        end
        GAP: begin
          if (stop) stopPend_q <= 1'b1;
          if (expire) begin
            state_q  <= DUB;
            durCnt_q <= 16'(DUB_MS - 1);
            period_q <= PERIOD_DUB;
            divEn_q  <= 1'b1;
          end
        end
        DUB: begin
          if (stop) stopPend_q <= 1'b1;
          // A stop seen on the final DUB edge still skips REST.
          if (expire) begin
            period_q <= '0;
            divEn_q  <= 1'b0;
            if (stopPend_q || stop) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              stopPend_q <= 1'b0;
            end else begin
              state_q  <= REST;
              durCnt_q <= restLoad(bpmLat_q);
            end
          end
        end
        REST: begin
          if (stop || (expire && stopPend_q)) begin
            state_q    <= IDLE;
            period_q   <= '0;
            divEn_q    <= 1'b0;
            busy_q     <= 1'b0;
            stopPend_q <= 1'b0;
          end else if (expire) begin
            state_q     <= LUB;
            durCnt_q    <= 16'(LUB_MS - 1);
            bpmLat_q    <= bpm_sel;
            period_q    <= PERIOD_LUB;
            divEn_q     <= 1'b1;
            beatPulse_q <= 1'b1;
`ifdef HB_COUNT_EN
            if (beatCnt_q != 16'hFFFF) beatCnt_q <= beatCnt_q + 16'd1;
`endif
          end
        end
        default: begin
          state_q  <= IDLE;
          period_q <= '0;
          divEn_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign period     = period_q;
  assign div_en     = divEn_q;
  assign busy       = busy_q;
  assign beat_pulse = beatPulse_q;
`ifdef HB_COUNT_EN
  assign beat_count = beatCnt_q;
`endif

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// Bench for heartbeat_sequencer: randomized beat/stop schedules, expected output segments
// (value + length in clk cycles) are queued by the driver and consumed by a negedge monitor.
module tb_heartbeat_sequencer;

  localparam int TD       = 12;
  localparam int LUB_CYC  = 100 * TD;
  localparam int GAP_CYC  = 80 * TD;
  localparam int DUB_CYC  = 100 * TD;
  localparam int TONE_CYC = LUB_CYC + GAP_CYC + DUB_CYC;
  localparam logic [3:0] P_LUB = 4'd1;
  localparam logic [3:0] P_DUB = 4'd2;

  typedef struct {
    logic [3:0] period;
    logic       divEn;
    logic       busy;
    int         len;
    logic       pulse;
    int         cnt;
  } seg_t;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] bpm_sel;
  logic [3:0] period;
  logic       div_en, busy, beat_pulse;
`ifdef HB_COUNT_EN
  logic [15:0] beat_count;
`endif

  seg_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   bpmPlan[4];

  heartbeat_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .bpm_sel(bpm_sel),
    .period(period),
    .div_en(div_en),
    .busy(busy),
    .beat_pulse(beat_pulse)
`ifdef HB_COUNT_EN
    ,
    .beat_count(beat_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: one full beat cycle in clk cycles for a BPM code.
  function automatic int beatCyc(input int code);
    int ms;
    case (code)
      0:       ms = 1000;
      1:       ms = 800;
      2:       ms = 600;
      default: ms = 500;
    endcase
    return ms * TD;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic pushSeg(input logic [3:0] p, input logic en, input logic b, input int len,
                         input logic pulse, input int cnt);
    seg_t s;
    s.period = p; s.divEn = en; s.busy = b; s.len = len; s.pulse = pulse; s.cnt = cnt;
    expQ.push_back(s);
  endtask

  // Queue the reference segments for a run, then drive start, BPM changes and the stop.
  task automatic applyStimulus(input int nBeats, input int stopAt, input bit pokeStart);
    int bStart[4];
    int acc, pos, last, target;
    bit done;
    last = nBeats - 1;
    acc  = 0;
    for (int k = 0; k < nBeats; k++) begin
      bStart[k] = acc;
      pushSeg(P_LUB, 1'b1, 1'b1, LUB_CYC, 1'b1, k + 1);
      pushSeg(4'd0, 1'b0, 1'b1, GAP_CYC, 1'b0, 0);
      pushSeg(P_DUB, 1'b1, 1'b1, DUB_CYC, 1'b0, 0);
      if (k < last) pushSeg(4'd0, 1'b0, 1'b1, beatCyc(bpmPlan[k]) - TONE_CYC, 1'b0, 0);
      else if (stopAt >= TONE_CYC) pushSeg(4'd0, 1'b0, 1'b1, stopAt - TONE_CYC + 1, 1'b0, 0);
      acc += beatCyc(bpmPlan[k]);
    end
    pushSeg(4'd0, 1'b0, 1'b0, 0, 1'b0, 0);

    bpm_sel = 2'(bpmPlan[0]);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pos   = 0;
    if (pokeStart && (nBeats > 1 || stopAt > 600)) begin
      while (pos < 600) begin @(posedge clk); #1; pos++; end
      start = 1'b1;
      @(posedge clk); #1; pos++;
      start = 1'b0;
    end
    for (int k = 0; k < last; k++) begin
      target = bStart[k] + TONE_CYC + $urandom_range(0, beatCyc(bpmPlan[k]) - TONE_CYC - 1);
      while (pos < target) begin @(posedge clk); #1; pos++; end
      bpm_sel = 2'(bpmPlan[k + 1]);
    end
    target = bStart[last] + stopAt;
    while (pos < target) begin @(posedge clk); #1; pos++; end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    checkOutput("idle_reached", int'(done), 1);
    repeat ($urandom_range(2, 10)) @(posedge clk);
    #1;
  endtask

  task automatic resetMidLub(input int r);
    int pos;
    pushSeg(P_LUB, 1'b1, 1'b1, r, 1'b1, 1);
    pushSeg(4'd0, 1'b0, 1'b0, 0, 1'b0, 0);
    bpm_sel = 2'($urandom_range(0, 3));
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pos   = 0;
    while (pos < r) begin @(posedge clk); #1; pos++; end
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_period", int'(period), 0);
    checkOutput("async_rst_div_en", int'(div_en), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: a change of {period, div_en, busy} closes the current segment against the queue.
  initial begin
    logic [5:0] prevT, curT;
    int         run;
    bit         started;
    seg_t       e;
    started = 1'b0;
    run     = 0;
    prevT   = '0;
    forever begin
      @(negedge clk);
      curT = {period, div_en, busy};
      if (started && curT == prevT) begin
        run++;
        if (run == 2) checkOutput("pulse_width", int'(beat_pulse), 0);
        else if (run > 2 && beat_pulse) checkOutput("stray_pulse", int'(beat_pulse), 0);
      end else begin
        if (started) begin
          if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL seg_unexpected: got outputs %0h for %0d cycles, expected no segment", prevT, run);
          end else begin
            e = expQ.pop_front();
            checkOutput("seg_outputs", int'(prevT), int'({e.period, e.divEn, e.busy}));
            if (e.len != 0) checkOutput("seg_length", run, e.len);
          end
        end
        started = 1'b1;
        prevT   = curT;
        run     = 1;
        if (expQ.size() != 0) begin
          e = expQ[0];
          checkOutput("beat_pulse", int'(beat_pulse), int'(e.pulse));
`ifdef HB_COUNT_EN
          if (e.pulse) checkOutput("beat_count", int'(beat_count), e.cnt);
`endif
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stopAt;
    rst = 1'b1; start = 1'b0; stop = 1'b0; bpm_sel = 2'd0;
    pushSeg(4'd0, 1'b0, 1'b0, 0, 1'b0, 0);
    #1;
    checkOutput("reset_period", int'(period), 0);
    checkOutput("reset_div_en", int'(div_en), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_beat_pulse", int'(beat_pulse), 0);
`ifdef HB_COUNT_EN
    checkOutput("reset_beat_count", int'(beat_count), 0);
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    checkOutput("start_stop_idle", int'(busy), 0);
    @(posedge clk); #1;

    $display("[TB] two beats at 60 BPM, stop during second GAP");
    bpmPlan[0] = 0; bpmPlan[1] = 0;
    applyStimulus(2, LUB_CYC + $urandom_range(0, GAP_CYC - 1), 1'b1);

    $display("[TB] BPM 120 then 75 changed mid-REST, stop during third GAP");
    bpmPlan[0] = 3; bpmPlan[1] = 1; bpmPlan[2] = 2;
    applyStimulus(3, LUB_CYC + $urandom_range(0, GAP_CYC - 1), 1'b0);

    $display("[TB] stop during REST");
    bpmPlan[0] = 2;
    applyStimulus(1, TONE_CYC + $urandom_range(0, beatCyc(2) - TONE_CYC - 1), 1'b1);

    $display("[TB] reset mid-LUB then a fresh run");
    resetMidLub($urandom_range(50, LUB_CYC - 50));
    bpmPlan[0] = $urandom_range(0, 3);
    applyStimulus(1, $urandom_range(0, LUB_CYC - 1), 1'b0);

    for (int n = 0; n < 3; n++) begin
      bpmPlan[0] = $urandom_range(0, 3);
      stopAt = $urandom_range(0, beatCyc(bpmPlan[0]) - 1);
      $display("[TB] random run %0d: bpm code %0d, stop at cycle %0d", n, bpmPlan[0], stopAt);
      applyStimulus(1, stopAt, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 1);
    checkOutput("final_busy", int'(busy), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/heartbeat_sequencer.md
Name: heartbeat_sequencer

Overview:
- Drives the period select and enable of the tone/blink clock divider so it plays a "lub-dub" heartbeat pattern.
- Each beat cycle runs LUB tone, GAP silence, DUB tone, then REST silence. Cycle length is selected by a BPM code.
- Sits between the top-level user controls (start/stop/BPM select) and the clk_divider `period` input. Runs on the 12 MHz system clock.

Parameters:
- TICK_DIV, 12000: clk cycles per 1 ms tick. Legal range is ≥2; benches use 12.
- LUB_MS, 100: LUB tone duration, in ticks.
- GAP_MS, 80: silence between LUB and DUB, in ticks.
- DUB_MS, 100: DUB tone duration, in ticks.
- PERIOD_LUB, 4'd1: divider period code during LUB (2400 Hz).
- PERIOD_DUB, 4'd2: divider period code during DUB (1200 Hz).

Ports:
- clk, input, 1: 12 MHz system clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: level-sampled request to begin sequencing.
- stop, input, 1: level-sampled request for a graceful stop.
- bpm_sel, input, 2: cycle length select. 0 = 60 BPM (1000 ms), 1 = 75 (800 ms), 2 = 100 (600 ms), 3 = 120 (500 ms).
- period, output, 4: period code to clk_divider. 4'd0 when silent.
- div_en, output, 1: high while a tone state is active.
- busy, output, 1: high in any state other than IDLE.
- beat_pulse, output, 1: one-cycle strobe on each entry to LUB.
- beat_count, output, 16: beats since start. Exists only with HB_COUNT_EN.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, period=0, div_en=0, busy=0, beat_pulse=0, beat_count=0, tick and duration counters 0, stop_pend=0, bpm latch=0.
- States: IDLE, LUB, GAP, DUB, REST.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 only while busy.
  - tick=1 on the cycle the counter equals TICK_DIV-1.
  - Counter is cleared on IDLE→LUB.
- Duration counter:
  - Loaded with the state duration minus 1 on state entry.
  - Decrements on tick.
  - The state exits on the tick where the counter is 0.
  - Net effect: each state lasts exactly duration×TICK_DIV clk cycles.
- REST duration = CYCLE_MS[bpm_lat] − LUB_MS − GAP_MS − DUB_MS.
  - bpm_sel is latched into bpm_lat on every LUB entry. Changing bpm_sel mid-cycle affects only the next cycle.
  - Parameters must keep REST ≥ 1 for all codes. With the defaults: 720, 520, 320, 220 ticks.
- Transitions:
  - IDLE→LUB: when start=1 and stop=0. If start and stop are both high, stop wins and the block stays IDLE.
  - LUB→GAP→DUB→REST: on expiry of each state.
  - REST→LUB: on expiry if stop_pend=0.
  - REST→IDLE: on expiry if stop_pend=1.
- Stop:
  - stop=1 in LUB, GAP or DUB sets stop_pend. The sequencer completes DUB, then goes to IDLE at the end of DUB (REST is skipped).
  - stop=1 in REST goes to IDLE on the next clk.
  - stop_pend is cleared on entry to IDLE.
- start while busy is ignored.
- Output mapping (registered, so it takes effect the cycle after the state change):
  - LUB: period=PERIOD_LUB, div_en=1.
  - DUB: period=PERIOD_DUB, div_en=1.
  - Other states: period=0, div_en=0.
- Latency: start sampled high at edge n gives busy=1, div_en=1, period=PERIOD_LUB and beat_pulse=1 after edge n.
- beat_pulse deasserts after edge n+1.
- Reset mid-operation forces reset values immediately and asynchronously.

Optional Feature:
- Macro: HB_COUNT_EN.
- Defined:
  - beat_count port is present.
  - Increments on each beat_pulse.
  - Saturates at 16'hFFFF.
  - Cleared on IDLE→LUB and on rst.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan (TICK_DIV=12, default durations):
- Reset then start pulse, bpm_sel=0:
  - beat_pulse once.
  - period=1/div_en=1 for 1200 clk.
  - period=0 for 960 clk.
  - period=2 for 1200 clk.
  - silence for 8640 clk.
  - Next beat_pulse exactly 12000 clk after the first.
- bpm_sel=3 during cycle 1, then changed to 1 mid-REST:
  - Cycle 1 (bpm_sel=3) REST = 2640 clk.
  - The change mid-REST does not alter the current REST.
  - Next cycle REST = 6240 clk (code 1).
- stop asserted during GAP:
  - DUB plays the full 1200 clk.
  - busy=0 immediately after DUB with no REST.
  - period=0.
- stop during REST: busy=0 and outputs silent on the following cycle. start and stop high together from IDLE: busy stays 0.
- rst asserted mid-LUB: outputs return to 0 asynchronously. A later start begins with a full 1200-clk LUB.
- HB_COUNT_EN defined: after 3 beat_pulses beat_count=3. After stop then start, beat_count=1 after the first new pulse.
